nn_datapath: RTL and testbench
==============================

Name: nn_datapath

Overview:
- Execution datapath directly downstream of the instruction-sequencing FSMs.
- Accepts one 32-bit instruction per start/finished handshake and executes it on a 16-entry register file of signed Q8.8 values.
- Supports set, get, saturating add, multiply, ReLU, random, mutate and multi-cycle dot product, for evaluating and mutating network weights.
- Returns a 32-bit result with finished.

Parameters:
- DATA_W, 16: register width, signed fixed point.
- FRAC_BITS, 8: fractional bits. Products are shifted right arithmetically by FRAC_BITS.
- LFSR_SEED, 16'hACE1: LFSR reset value. Must be nonzero.

Ports:
- clock  input  1  system clock.
- resetn  input  1  reset; resetn, synchronous, active-low; clock clock.
- start  input  1  instruction request from the FSM.
- instruction  input  `INSTRUCTION_WIDTH (32)  bits [31:28] opcode, [27:24] rd, [23:20] rs, [19:16] rt, [15:0] imm.
- finished  output  1  high when idle and the result is valid.
- result  output  `RESULT_WIDTH (32)  bits [15:0] value, [16] illegal-opcode flag, [31:17] zero.

Behaviour:
- Reset values: finished=1, result=0, all registers=0, lfsr=LFSR_SEED, state=IDLE, armed=1. Reset mid-operation aborts the operation: no register write, finished=1 on the next cycle.
- Accept condition: state==IDLE && start && armed. On the accept edge A:
  - latch instruction;
  - finished<=0;
  - armed<=0.
- armed returns to 1 on any edge where start==0.
  - The FSM holds start for 2 cycles, so one request is exactly one execution.
  - start held continuously is never re-executed.
- start while busy is ignored. The instruction input is don't-care after A.
- Completion edge A+L: result and register write update together, and finished<=1. result holds until the next accept.
- Opcodes, with latency L. All writes saturate to [-32768, 32767]. result[15:0] is the written or read value.
  - 0 NOP, L=2: result=0.
  - 1 SET, L=2: r[rd]=imm.
  - 2 GET, L=2: result=r[rs].
  - 3 ADD, L=2: r[rd]=sat(r[rs]+r[rt]), 17-bit sum.
  - 4 MUL, L=3: r[rd]=sat((r[rs]*r[rt])>>>FRAC_BITS). The 32-bit product is registered one cycle.
  - 5 RELU, L=2: r[rd]= r[rs]<0 ? 0 : r[rs].
  - 6 RAND, L=2: r[rd]=lfsr value sampled at A+1.
  - 7 MUTATE, L=3: r[rd]=sat(r[rs] + ($signed(lfsr)>>>imm[3:0])).
  - 8 DOT, L=n+3 with n=imm[3:0]+1:
    - acc = sum over i=0..n-1 of r[(rs+i)%16]*r[(rt+i)%16];
    - acc is 40-bit signed, accumulated one product per cycle;
    - then r[rd]=sat(acc>>>FRAC_BITS).
    - Indices wrap mod 16. Reads use pre-operation values even if rd overlaps a source.
  - 9..15 illegal, L=2: no write, result={15'd0,1'b1,16'd0}.
- LFSR: 16-bit Galois, mask 16'hB400, steps every cycle including while idle. The state never reaches 0.
- FSM states: IDLE -> EXEC (simple ops finish here) -> {MUL_WAIT | DOT_LOOP} -> DONE -> IDLE. DONE performs the saturate/write and asserts finished.
- The register file is written only at completion; there are no partial writes.

Decomposition:
- Opcode defines (DP_OP_*), field bit positions and the result flag position go in constants.h. They are shared with every FSM that issues datapath instructions.
- The saturation width rules live in the same file as constants.
- One sub-module, lfsr16 (clock, resetn, seed param, 16-bit out), shared with the population-mutation logic.

Test Plan:
1. SET r1=0x0180, SET r2=0x0200, MUL r3=r1,r2, GET r3.
   - Required: result[15:0]=0x0300.
   - finished low exactly 3 cycles for MUL, 2 cycles for the others.
2. Saturation.
   - SET r1=r2=0x7000, ADD r3 -> 0x7FFF.
   - SET r1=r2=0x9000, ADD r3 -> 0x8000.
   - MUL of 0x7F00*0x7F00 -> 0x7FFF.
3. DOT with rs=14, rt=0, imm=2 (n=3), r14=r15=r0=r1=r2=0x0100, rd=14.
   - Required: result=0x0300 after 6 cycles. The register-index wrap and source-overlap rule both hold.
4. RELU.
   - r5=0xFF00 -> 0x0000.
   - r5=0x0100 -> 0x0100.
   - Opcode 0xC -> result=0x0001_0000, no register changed (all 16 read back via GET).
5. Handshake.
   - start held 2 cycles with NOP -> exactly one execution.
   - start held 20 cycles with ADD r1=r1+r1, r1=1 -> r1=2 only.
   - start pulsed during DOT -> ignored.
6. Reset.
   - Assert resetn=0 for 1 cycle mid-DOT -> finished=1 and result=0 the next cycle.
   - GET rd returns 0.
   - Two RAND results after reset are nonzero and differ.

Source files
------------

// File: rtl/nn_datapath_pkg.sv
// nn_datapath_pkg
//   Constants shared by the datapath and every FSM that issues datapath
//   instructions: opcode encoding, instruction/result field positions,
//   FSM state encoding and the saturation rule applied to register writes.
//   No ports (package).
package nn_datapath_pkg;

    localparam int INSTRUCTION_WIDTH = 32;
    localparam int RESULT_WIDTH      = 32;
    localparam int NUM_REGS          = 16;
    localparam int ACC_W             = 40;  // dot-product accumulator width

    // Instruction fields
    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 28;
    localparam int RD_MSB  = 27;
    localparam int RD_LSB  = 24;
    localparam int RS_MSB  = 23;
    localparam int RS_LSB  = 20;
    localparam int RT_MSB  = 19;
    localparam int RT_LSB  = 16;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    // Result layout: [15:0] value, [16] illegal-opcode flag, rest zero
    localparam int RESULT_FLAG_BIT = 16;

    typedef enum logic [3:0] {
        DP_OP_NOP    = 4'd0,
        DP_OP_SET    = 4'd1,
        DP_OP_GET    = 4'd2,
        DP_OP_ADD    = 4'd3,
        DP_OP_MUL    = 4'd4,
        DP_OP_RELU   = 4'd5,
        DP_OP_RAND   = 4'd6,
        DP_OP_MUTATE = 4'd7,
        DP_OP_DOT    = 4'd8
    } dp_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_MUL_WAIT,
        ST_DOT_LOOP,
        ST_DONE
    } dp_state_t;

    // Clamp a wide signed value to the signed range of a w-bit register.
    function automatic logic signed [ACC_W-1:0] sat_to(input logic signed [ACC_W-1:0] v,
                                                        input int w);
        logic signed [ACC_W-1:0] hi;
        logic signed [ACC_W-1:0] lo;
        hi = (ACC_W'(1) <<< (w - 1)) - ACC_W'(1);
        lo = ~hi;
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        else             return v;
    endfunction

endpackage

// File: rtl/nn_datapath_if.sv
// nn_datapath_if
//   Instruction/result handshake between a sequencing FSM (master) and the
//   datapath (slave).
//   start       : FSM -> datapath, instruction request
//   instruction : FSM -> datapath, 32-bit instruction word
//   finished    : datapath -> FSM, idle and result valid
//   result      : datapath -> FSM, 32-bit result word
interface nn_datapath_if;
    import nn_datapath_pkg::*;

    logic                         start;
    logic [INSTRUCTION_WIDTH-1:0] instruction;
    logic                         finished;
    logic [RESULT_WIDTH-1:0]      result;

    modport master (output start, instruction, input finished, result);
    modport slave  (input start, instruction, output finished, result);

endinterface

// File: rtl/nn_datapath_lfsr16.sv
// lfsr16
//   16-bit Galois LFSR (mask 16'hB400), steps every cycle. With a nonzero
//   seed the state never reaches zero.
//   clock  : system clock
//   resetn : synchronous active-low reset, loads SEED
//   out    : current LFSR state
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clock,
    input  logic        resetn,
    output logic [15:0] out
);

    localparam logic [15:0] MASK = 16'hB400;

    always_ff @(posedge clock) begin
        if (!resetn) out <= SEED;
        else         out <= {1'b0, out[15:1]} ^ (out[0] ? MASK : 16'h0000);
    end

endmodule

// File: rtl/nn_datapath.sv
// nn_datapath
//   Executes one instruction per start/finished handshake on a 16-entry
//   register file of signed fixed-point values (SET/GET/ADD/MUL/RELU/RAND/
//   MUTATE/DOT). All register writes saturate and happen only in DONE.
//   clock  : system clock
//   resetn : synchronous active-low reset; aborts any operation in flight
//   bus    : slave side of nn_datapath_if (start, instruction, finished, result)
module nn_datapath
    import nn_datapath_pkg::*;
#(
    parameter int          DATA_W    = 16,
    parameter int          FRAC_BITS = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic          clock,
    input  logic          resetn,
    nn_datapath_if.slave  bus
);

    dp_state_t                    state;
    logic                         armed;
    logic [INSTRUCTION_WIDTH-1:0] instr_q;
    logic signed [DATA_W-1:0]     rf [NUM_REGS];
    logic [15:0]                  lfsr_q;
    logic signed [2*DATA_W-1:0]   prod;   // MUL product, MUTATE offset, DOT pipeline product
    logic signed [ACC_W-1:0]      acc;
    logic signed [ACC_W-1:0]      wide;   // unsaturated value written in DONE
    logic [4:0]                   idx;
    logic                         wr_en;
    logic                         illegal;
    logic                         finished_q;
    logic [RESULT_WIDTH-1:0]      result_q;

    logic [3:0]               op, rd, rs, rt;
    logic [15:0]              imm;
    logic [3:0]               a_idx, b_idx;
    logic [4:0]               dot_n;
    logic signed [DATA_W-1:0] rs_val, rt_val, op_a, op_b, sat_v;
    logic                     accept;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clock  (clock),
        .resetn (resetn),
        .out    (lfsr_q)
    );

    always_comb begin
        op     = instr_q[OP_MSB:OP_LSB];
        rd     = instr_q[RD_MSB:RD_LSB];
        rs     = instr_q[RS_MSB:RS_LSB];
        rt     = instr_q[RT_MSB:RT_LSB];
        imm    = instr_q[IMM_MSB:IMM_LSB];
        dot_n  = {1'b0, imm[3:0]} + 5'd1;
        // 4-bit adds wrap the dot-product indices mod 16
        a_idx  = rs + idx[3:0];
        b_idx  = rt + idx[3:0];
        rs_val = rf[rs];
        rt_val = rf[rt];
        op_a   = rf[a_idx];
        op_b   = rf[b_idx];
        sat_v  = DATA_W'(sat_to(wide, DATA_W));
        accept = (state == ST_IDLE) && bus.start && armed;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            armed      <= 1'b1;
            instr_q    <= '0;
            prod       <= '0;
            acc        <= '0;
            wide       <= '0;
            idx        <= '0;
            wr_en      <= 1'b0;
            illegal    <= 1'b0;
            finished_q <= 1'b1;
            result_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
        end else begin
            // A held start must drop before another request is taken.
            if (!bus.start)  armed <= 1'b1;
            else if (accept) armed <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        instr_q    <= bus.instruction;
                        finished_q <= 1'b0;
                        state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    wr_en   <= 1'b0;
                    illegal <= 1'b0;
                    wide    <= '0;
                    state   <= ST_DONE;
                    case (op)
                        DP_OP_NOP: ;
                        DP_OP_SET: begin
                            wr_en <= 1'b1;
                            wide  <= ACC_W'($signed(imm));
                        end
                        DP_OP_GET: wide <= ACC_W'(rs_val);
                        DP_OP_ADD: begin
                            wr_en <= 1'b1;
                            wide  <= ACC_W'(rs_val) + ACC_W'(rt_val);
                        end
                        DP_OP_MUL: begin
                            wr_en <= 1'b1;
                            prod  <= rs_val * rt_val;
                            state <= ST_MUL_WAIT;
                        end
                        DP_OP_RELU: begin
                            wr_en <= 1'b1;
                            wide  <= rs_val[DATA_W-1] ? '0 : ACC_W'(rs_val);
                        end
                        DP_OP_RAND: begin
                            wr_en <= 1'b1;
                            wide  <= ACC_W'($signed(lfsr_q));
                        end
                        DP_OP_MUTATE: begin
                            // offset parked in prod, added to r[rs] next cycle
                            wr_en <= 1'b1;
                            prod  <= (2*DATA_W)'($signed(lfsr_q) >>> imm[3:0]);
                            state <= ST_MUL_WAIT;
                        end
                        DP_OP_DOT: begin
                            wr_en <= 1'b1;
                            acc   <= '0;
                            idx   <= '0;
                            state <= ST_DOT_LOOP;
                        end
                        default: illegal <= 1'b1;
                    endcase
                end
                ST_MUL_WAIT: begin
                    wide  <= (op == DP_OP_MUL) ? ACC_W'(prod >>> FRAC_BITS)
                                               : ACC_W'(rs_val) + ACC_W'(prod);
                    state <= ST_DONE;
                end
                ST_DOT_LOOP: begin
                    // Product registered one cycle, accumulated the next:
                    // n products take n+1 iterations.
                    if (idx < dot_n) prod <= op_a * op_b;
                    if (idx != 5'd0) acc  <= acc + ACC_W'(prod);
                    if (idx == dot_n) begin
                        wide  <= (acc + ACC_W'(prod)) >>> FRAC_BITS;
                        state <= ST_DONE;
                    end
                    idx <= idx + 5'd1;
                end
                ST_DONE: begin
                    if (wr_en) rf[rd] <= sat_v;
                    result_q   <= {{(RESULT_WIDTH-RESULT_FLAG_BIT-1){1'b0}}, illegal, 16'(sat_v)};
                    finished_q <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.finished = finished_q;
    assign bus.result   = result_q;

endmodule

// File: tb/tb_nn_datapath.sv
// tb_nn_datapath
//   Scoreboard bench: the stimulus side pushes expected {result, latency}
//   from a plain-arithmetic reference model; a monitor pops and compares
//   each time finished rises.
module tb_nn_datapath;
    import nn_datapath_pkg::*;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    nn_datapath_if bus();

    nn_datapath #(.DATA_W(16), .FRAC_BITS(8), .LFSR_SEED(16'hACE1)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t               exp_q[$];
    int                 checks = 0;
    int                 errors = 0;
    logic signed [15:0] ref_rf [16];
    logic [15:0]        ref_lfsr;

    // Reference LFSR: Galois, mask 16'hB400, advancing every clock.
    always @(posedge clock) begin
        if (!resetn) ref_lfsr <= 16'hACE1;
        else         ref_lfsr <= (ref_lfsr >> 1) ^ (ref_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic logic [15:0] sat16(input longint v);
        if (v > 32767)  return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return v[15:0];
    endfunction

    function automatic logic [31:0] mk(input int op, input int rd, input int rs,
                                       input int rt, input int imm);
        return {4'(op), 4'(rd), 4'(rs), 4'(rt), 16'(imm)};
    endfunction

    // Applies one instruction to the reference register file.
    function automatic void model(input logic [31:0] ins, input logic [15:0] lf,
                                  output logic [31:0] res, output int lat);
        logic [3:0]  op, rd, rs, rt;
        logic [15:0] imm;
        longint      a, b, v, sum;
        int          n;
        bit          wr;
        op  = ins[31:28]; rd = ins[27:24]; rs = ins[23:20]; rt = ins[19:16];
        imm = ins[15:0];
        a   = longint'(ref_rf[rs]);
        b   = longint'(ref_rf[rt]);
        v   = 0; wr = 1'b0; lat = 2;
        case (op)
            4'd0: ;
            4'd1: begin v = longint'($signed(imm)); wr = 1'b1; end
            4'd2: v = a;
            4'd3: begin v = a + b; wr = 1'b1; end
            4'd4: begin v = (a * b) >>> 8; wr = 1'b1; lat = 3; end
            4'd5: begin v = (a < 0) ? 0 : a; wr = 1'b1; end
            4'd6: begin v = longint'($signed(lf)); wr = 1'b1; end
            4'd7: begin v = a + (longint'($signed(lf)) >>> imm[3:0]); wr = 1'b1; lat = 3; end
            4'd8: begin
                n = int'(imm[3:0]) + 1;
                sum = 0;
                for (int i = 0; i < n; i++)
                    sum += longint'(ref_rf[(int'(rs) + i) % 16]) * longint'(ref_rf[(int'(rt) + i) % 16]);
                v = sum >>> 8; wr = 1'b1; lat = n + 3;
            end
            default: ;
        endcase
        if (op > 4'd8) res = 32'h0001_0000;
        else           res = {16'h0000, sat16(v)};
        if (wr) ref_rf[rd] = sat16(v);
    endfunction

    // Monitor: one expected entry per completion, latency = cycles finished was low.
    int low_cnt = 0;
    always @(negedge clock) begin : monitor
        exp_t e;
        if (!resetn) low_cnt = 0;
        else if (!bus.finished) low_cnt++;
        else if (low_cnt != 0) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_completion: result %h with nothing pending", bus.result);
            end else begin
                e = exp_q.pop_front();
                check("result", bus.result, e.res);
                check("latency", 32'(low_cnt), 32'(e.lat));
            end
            low_cnt = 0;
        end
    end

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clock);
        while (!bus.finished && k < 300) begin
            @(negedge clock);
            k++;
        end
        if (!bus.finished) begin
            checks++; errors++;
            $display("FAIL idle_timeout: finished still 0 after %0d cycles, required 1", k);
        end
    endtask

    // Drive one request, start held for 'hold' clock edges.
    task automatic issue(input logic [31:0] ins, input int hold);
        logic [31:0] r;
        int          l;
        wait_idle();
        bus.instruction = ins;
        bus.start       = 1'b1;
        @(posedge clock); #1;           // accept edge A; ref_lfsr now holds the A+1 sample
        model(ins, ref_lfsr, r, l);
        exp_q.push_back('{r, l});
        bus.instruction = $urandom;     // don't-care after accept
        for (int i = 1; i < hold; i++) @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        @(negedge clock);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : stim
        logic [31:0] r1, r2;
        bus.start       = 1'b0;
        bus.instruction = '0;
        for (int i = 0; i < 16; i++) ref_rf[i] = '0;
        repeat (3) @(negedge clock);
        check("reset_finished", 32'(bus.finished), 32'd1);
        check("reset_result", bus.result, 32'd0);
        resetn = 1'b1;

        // basic MUL flow
        issue(mk(1, 1, 0, 0, 16'h0180), 2);
        issue(mk(1, 2, 0, 0, 16'h0200), 2);
        issue(mk(4, 3, 1, 2, 0), 2);
        issue(mk(2, 0, 3, 0, 0), 2);

        // saturation
        issue(mk(1, 1, 0, 0, 16'h7000), 2);
        issue(mk(1, 2, 0, 0, 16'h7000), 2);
        issue(mk(3, 3, 1, 2, 0), 2);
        issue(mk(1, 1, 0, 0, 16'h9000), 2);
        issue(mk(1, 2, 0, 0, 16'h9000), 2);
        issue(mk(3, 3, 1, 2, 0), 2);
        issue(mk(1, 1, 0, 0, 16'h7F00), 2);
        issue(mk(4, 3, 1, 1, 0), 2);

        // DOT with index wrap and rd overlapping a source
        foreach (r1[i]) ;
        issue(mk(1, 14, 0, 0, 16'h0100), 2);
        issue(mk(1, 15, 0, 0, 16'h0100), 2);
        issue(mk(1, 0, 0, 0, 16'h0100), 2);
        issue(mk(1, 1, 0, 0, 16'h0100), 2);
        issue(mk(1, 2, 0, 0, 16'h0100), 2);
        issue(mk(8, 14, 14, 0, 2), 2);
        issue(mk(2, 0, 14, 0, 0), 2);

        // RELU and illegal opcode
        issue(mk(1, 5, 0, 0, 16'hFF00), 2);
        issue(mk(5, 6, 5, 0, 0), 2);
        issue(mk(1, 5, 0, 0, 16'h0100), 2);
        issue(mk(5, 6, 5, 0, 0), 2);
        issue(mk(12, 7, 1, 2, 16'h1234), 2);
        for (int i = 0; i < 16; i++) issue(mk(2, 0, i, 0, 0), 2);

        // handshake: held start executes once, busy start ignored
        issue(mk(0, 0, 0, 0, 0), 2);
        issue(mk(1, 1, 0, 0, 1), 2);
        issue(mk(3, 1, 1, 1, 0), 20);
        issue(mk(2, 0, 1, 0, 0), 2);
        issue(mk(8, 4, 0, 0, 5), 2);
        bus.instruction = mk(1, 9, 0, 0, 16'h5555);
        bus.start       = 1'b1;
        @(negedge clock);
        bus.start       = 1'b0;
        issue(mk(2, 0, 9, 0, 0), 2);

        // randomized traffic
        for (int t = 0; t < 150; t++) begin
            logic [31:0] ins;
            ins        = $urandom;
            ins[31:28] = 4'($urandom_range(0, 9));
            issue(ins, $urandom_range(1, 4));
        end

        // reset in the middle of a long DOT
        issue(mk(8, 14, 14, 0, 15), 2);
        repeat (3) @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        check("midop_reset_finished", 32'(bus.finished), 32'd1);
        check("midop_reset_result", bus.result, 32'd0);
        exp_q.delete();
        for (int i = 0; i < 16; i++) ref_rf[i] = '0;
        resetn = 1'b1;
        issue(mk(2, 0, 14, 0, 0), 2);
        issue(mk(6, 3, 0, 0, 0), 2);
        wait_idle();
        r1 = bus.result;
        issue(mk(6, 4, 0, 0, 0), 2);
        wait_idle();
        r2 = bus.result;
        check("rand1_nonzero", 32'(r1 != 32'd0), 32'd1);
        check("rand2_nonzero", 32'(r2 != 32'd0), 32'd1);
        check("rand_differ", 32'(r1 != r2), 32'd1);

        repeat (2) @(negedge clock);
        check("pending_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
